uart_rx_framed: RTL and testbench
=================================

Name: uart_rx_framed

Overview:
Parametrised UART receiver and successor to the basic 8N1 receiver. Supports configurable data width, parity mode and stop-bit count, with metastability-hardened input, start-glitch rejection and a valid/ready output handshake. Reports parity, framing, overrun and break conditions per frame. Sits between the board RX pin and the command/FIFO logic on the iCE40UP5K.

Parameters:
CLOCK_FREQ, 12000000, system clock frequency in Hz
BAUD_RATE, 115200, line bit rate; CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE, elaboration error if < 4
DATA_BITS, 8, payload bits per frame, legal range 5..9
PARITY, 0, parity mode: 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, stop bits per frame, 1 or 2

Ports:
clk  input  1  system clock; single clock domain
reset  input  1  synchronous, active-high reset
rx  input  1  asynchronous serial line; idle high
data_out  output  DATA_BITS  received payload, LSB first on the wire
data_valid  output  1  frame available; held high until accepted
data_ready  input  1  consumer accepts when data_valid && data_ready on a rising edge
parity_error  output  1  parity mismatch on the held frame; forced 0 when PARITY=0
frame_error  output  1  at least one stop-bit sample was low on the held frame
break_detect  output  1  frame_error set and every data and parity sample was 0
overrun_error  output  1  one-cycle pulse when a frame completes while data_valid is still high

Behaviour:
- Reset values:
  - data_out = 0; data_valid, parity_error, frame_error, break_detect, overrun_error = 0.
  - FSM in IDLE, counters = 0, synchroniser flops = 1.
  - Reset mid-frame abandons the frame with no output.
- Input path: rx passes through a 2-flop synchroniser; all decisions use the synchronised rx_s, which lags rx by 2 cycles.
- Bit counter cnt counts 0..CLKS_PER_BIT-1. HALF = CLKS_PER_BIT/2, integer division.
- FSM states: IDLE, START, DATA, PAR, STOP, WAIT_HIGH.
- IDLE: when rx_s = 0, go to START with cnt = 0.
- START: when cnt = HALF-1, sample rx_s.
  - rx_s = 1: glitch; return to IDLE with no output or flags.
  - rx_s = 0: go to DATA with cnt = 0 and bit index = 0.
- DATA: sample rx_s when cnt = CLKS_PER_BIT-1 (mid-bit) into shift[index]. After DATA_BITS samples, go to PAR if PARITY != 0, otherwise go to STOP.
- PAR: sample one bit mid-bit.
  - Even parity: error if XOR(data, pbit) = 1.
  - Odd parity: error if XOR(data, pbit) = 0.
- STOP: take STOP_BITS mid-bit samples; any low sample sets the frame_error candidate. The cycle of the last stop sample is the completion cycle.
- Completion, with data_valid = 0:
  - On the next edge, load data_out and all three error flags, and set data_valid = 1.
  - Latency from the last stop-bit mid-sample to data_valid is 1 cycle.
- Completion, with data_valid = 1 and not accepted that same edge:
  - New frame is discarded; held data and flags are unchanged.
  - overrun_error pulses high for exactly 1 cycle.
- Simultaneous accept and completion: the accept wins, the new frame is loaded, and there is no overrun.
- Accept without completion: data_valid clears on the accept edge; data_out and the flags hold their last value.
- After completion:
  - No framing error: return to IDLE immediately, so back-to-back frames are legal.
  - Framing error: enter WAIT_HIGH and stay until rx_s = 1 before returning to IDLE. A break does not retrigger starts.
- Parity bit is included in the break "all zero" check only when PARITY != 0.

Decomposition:
- Package uart_pkg holds:
  - FSM state enum.
  - Parity mode constants PARITY_NONE / EVEN / ODD.
  - Function clks_per_bit(freq, baud).
- One natural sub-module, uart_rx_sync: 2-flop synchroniser with reset value 1, parametrised stage count, default 2.
- Counters and the FSM stay in uart_rx_framed.

Test Plan:
Common bench setting: CLOCK_FREQ=16, BAUD_RATE=1 (16 clocks/bit) unless noted; rx is driven 16 clocks per bit.
1. 8N1, send 0xA5, data_ready=1 → data_valid pulses 1 cycle, data_out=0xA5, all error flags 0.
2. 8E1, send 0x3C with parity bit 1 (wrong; correct is 0) → data_out=0x3C, parity_error=1. Then resend with parity 0 → parity_error=0. Repeat with 7O2 and 0x55 plus correct parity 1 → no errors.
3. Start glitch: rx low for 4 clocks, then high → no data_valid, FSM back in IDLE; a following valid 0x81 frame is received correctly.
4. Framing and break: 8N1 frame 0x00 with stop bit low, rx held low 40 bit periods → frame_error=1, break_detect=1, exactly one data_valid. No further frames until rx returns high, then 0x7E is received.
5. Overrun: data_ready=0, send 0x11 then 0x22 back-to-back → data_out stays 0x11, overrun_error high exactly 1 cycle at the 0x22 completion. Assert data_ready, then send 0x33 → data_out=0x33.
6. Reset mid-frame after 3 data bits → all outputs 0 next cycle, no data_valid. A following 0xC3 frame is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART receiver.
// Pure declarations: no latency, no flow control.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PAR,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    function automatic int clks_per_bit(input int freq, input int baud);
        return freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for the asynchronous rx line, resets to idle-high.
// Latency STAGES cycles; no backpressure.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    if (STAGES < 2) begin : g_bad_stages
        $error("uart_rx_sync needs at least 2 stages");
    end

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx_framed.sv
// Parametrised UART receiver with parity/framing/break/overrun reporting.
// data_valid 1 cycle after last stop sample; held until data_ready, new frames dropped meanwhile.
module uart_rx_framed
    import uart_pkg::*;
#(
    parameter int CLOCK_FREQ = 12000000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 break_detect,
    output logic                 overrun_error
);

    localparam int CPB   = clks_per_bit(CLOCK_FREQ, BAUD_RATE);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);
    localparam int IDX_W = 4;

    if (CPB < 4) begin : g_bad_baud
        $error("CLKS_PER_BIT must be at least 4");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_width
        $error("DATA_BITS must be 5..9");
    end
    if (PARITY < PARITY_NONE || PARITY > PARITY_ODD) begin : g_bad_parity
        $error("PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
        $error("STOP_BITS must be 1 or 2");
    end

    rx_state_t            r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_pbit;
    logic                 r_ferr;

    logic w_rx_s;
    logic w_mid;
    logic w_accept;
    logic w_stop_bad;
    logic w_par_x;
    logic w_par_err;
    logic w_break;

    uart_rx_sync #(
        .STAGES (2)
    ) u_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (rx),
        .o_q     (w_rx_s)
    );

    assign w_mid      = (r_cnt == CNT_W'(CPB - 1));
    assign w_accept   = data_valid & data_ready;
    // Includes the stop sample being taken this cycle, so completion sees the full frame.
    assign w_stop_bad = r_ferr | ~w_rx_s;
    assign w_par_x    = (^r_shift) ^ r_pbit;
    assign w_par_err  = (PARITY == PARITY_EVEN) ? w_par_x :
                        (PARITY == PARITY_ODD)  ? ~w_par_x : 1'b0;
    assign w_break    = w_stop_bad && (r_shift == '0) &&
                        ((PARITY == PARITY_NONE) || !r_pbit);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_stop_idx    <= 1'b0;
            r_shift       <= '0;
            r_pbit        <= 1'b0;
            r_ferr        <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            parity_error  <= 1'b0;
            frame_error   <= 1'b0;
            break_detect  <= 1'b0;
            overrun_error <= 1'b0;
        end else begin
            overrun_error <= 1'b0;
            if (w_accept) begin
                data_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        r_state <= ST_START;
                        r_cnt   <= '0;
                    end
                end

                ST_START: begin
                    if (r_cnt == CNT_W'(HALF - 1)) begin
                        r_cnt <= '0;
                        if (w_rx_s) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state    <= ST_DATA;
                            r_idx      <= '0;
                            r_stop_idx <= 1'b0;
                            r_ferr     <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_DATA: begin
                    if (w_mid) begin
                        r_cnt   <= '0;
                        r_shift <= {w_rx_s, r_shift[DATA_BITS-1:1]};
                        r_idx   <= r_idx + 1'b1;
                        if (r_idx == IDX_W'(DATA_BITS - 1)) begin
                            r_state <= (PARITY != PARITY_NONE) ? ST_PAR : ST_STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_PAR: begin
                    if (w_mid) begin
                        r_cnt   <= '0;
                        r_pbit  <= w_rx_s;
                        r_state <= ST_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_STOP: begin
                    if (w_mid) begin
                        r_cnt      <= '0;
                        r_ferr     <= w_stop_bad;
                        r_stop_idx <= 1'b1;
                        if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                            // An accept on this same edge frees the holding register.
                            if (!data_valid || w_accept) begin
                                data_out     <= r_shift;
                                parity_error <= w_par_err;
                                frame_error  <= w_stop_bad;
                                break_detect <= w_break;
                                data_valid   <= 1'b1;
                            end else begin
                                overrun_error <= 1'b1;
                            end
                            r_state <= w_stop_bad ? ST_WAIT_HIGH : ST_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                ST_WAIT_HIGH: begin
                    if (w_rx_s) begin
                        r_state <= ST_IDLE;
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_framed.sv
// Scoreboard bench for uart_rx_framed: 8N1, 8E1 and 7O2 instances at 16 clocks/bit.
module tb_uart_rx_framed;

    localparam int CPB = 16;
    // sync (2) + idle detect (1) + half start bit + 8 data + 1 stop bit
    localparam int LAT_8N1 = 3 + CPB / 2 + 9 * CPB;

    typedef struct {
        int         which;
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] rx_v;
    logic       data_ready;

    logic [7:0] dout0, dout1;
    logic [6:0] dout2;
    logic       dv0, pe0, fe0, bk0, ov0;
    logic       dv1, pe1, fe1, bk1, ov1;
    logic       dv2, pe2, fe2, bk2, ov2;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   acc0 = 0, acc1 = 0, acc2 = 0;
    int   vcnt0 = 0;
    int   ovcnt = 0;
    int   ov_cyc = 0;
    int   rise0 = 0;
    logic dv0_q = 1'b0;
    int   last_start = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_framed #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_dut8n1 (
        .clk(clk), .reset(reset), .rx(rx_v[0]), .data_out(dout0), .data_valid(dv0),
        .data_ready(data_ready), .parity_error(pe0), .frame_error(fe0),
        .break_detect(bk0), .overrun_error(ov0));

    uart_rx_framed #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_dut8e1 (
        .clk(clk), .reset(reset), .rx(rx_v[1]), .data_out(dout1), .data_valid(dv1),
        .data_ready(data_ready), .parity_error(pe1), .frame_error(fe1),
        .break_detect(bk1), .overrun_error(ov1));

    uart_rx_framed #(.CLOCK_FREQ(16), .BAUD_RATE(1), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2)) u_dut7o2 (
        .clk(clk), .reset(reset), .rx(rx_v[2]), .data_out(dout2), .data_valid(dv2),
        .data_ready(data_ready), .parity_error(pe2), .frame_error(fe2),
        .break_detect(bk2), .overrun_error(ov2));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic on_accept(input int k, input logic [8:0] d, input logic pe,
                             input logic fe, input logic bk);
        exp_t e;
        chk($sformatf("d%0d_expected_frame", k), int'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk($sformatf("d%0d_which", k), k, e.which);
            chk($sformatf("d%0d_data", k), d, e.data);
            chk($sformatf("d%0d_parity_err", k), pe, e.perr);
            chk($sformatf("d%0d_frame_err", k), fe, e.ferr);
            chk($sformatf("d%0d_break", k), bk, e.brk);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (dv0 && data_ready) begin
                acc0++;
                on_accept(0, {1'b0, dout0}, pe0, fe0, bk0);
            end
            if (dv1 && data_ready) begin
                acc1++;
                on_accept(1, {1'b0, dout1}, pe1, fe1, bk1);
            end
            if (dv2 && data_ready) begin
                acc2++;
                on_accept(2, {2'b0, dout2}, pe2, fe2, bk2);
            end
            if (dv0) vcnt0++;
            if (dv0 && !dv0_q) rise0 = cyc;
            if (ov0) begin
                ovcnt++;
                ov_cyc = cyc;
            end
        end
        dv0_q = dv0;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input int k, input logic b);
        rx_v[k] = b;
        tick(CPB);
    endtask

    task automatic send(input int k, input logic [8:0] d, input int nbits, input int pmode,
                        input logic pbit, input int nstop, input logic [1:0] stops,
                        input bit push);
        exp_t       e;
        logic [8:0] m;
        logic       px;
        m  = 9'((1 << nbits) - 1);
        px = (^(d & m)) ^ pbit;
        e.which = k;
        e.data  = d & m;
        e.perr  = (pmode == 1) ? px : (pmode == 2) ? ~px : 1'b0;
        e.ferr  = (nstop == 1) ? ~stops[0] : ~(stops[0] & stops[1]);
        e.brk   = e.ferr && (e.data == 9'd0) && (pmode == 0 || pbit == 1'b0);
        if (push) sb.push_back(e);
        last_start = cyc;
        drive_bit(k, 1'b0);
        for (int i = 0; i < nbits; i++) drive_bit(k, d[i]);
        if (pmode != 0) drive_bit(k, pbit);
        for (int s = 0; s < nstop; s++) drive_bit(k, stops[s]);
    endtask

    initial begin
        int base;
        int t22;
        reset      = 1'b1;
        rx_v       = 3'b111;
        data_ready = 1'b1;
        tick(3);
        chk("rst_data_out", dout0, 0);
        chk("rst_data_valid", dv0, 0);
        chk("rst_parity", pe0, 0);
        chk("rst_frame", fe0, 0);
        chk("rst_break", bk0, 0);
        chk("rst_overrun", ov0, 0);
        reset = 1'b0;
        tick(CPB * 2);

        // 8N1 basic frame, latency and one-cycle valid pulse
        base = vcnt0;
        send(0, 9'h0A5, 8, 0, 1'b0, 1, 2'b11, 1'b1);
        chk("lat_8n1", rise0 - last_start, LAT_8N1);
        tick(CPB * 2);
        chk("valid_pulse_len", vcnt0 - base, 1);

        // Even parity wrong then right; odd parity with two stop bits
        send(1, 9'h03C, 8, 1, 1'b1, 1, 2'b11, 1'b1);
        tick(CPB);
        send(1, 9'h03C, 8, 1, 1'b0, 1, 2'b11, 1'b1);
        tick(CPB);
        send(2, 9'h055, 7, 2, 1'b1, 2, 2'b11, 1'b1);
        tick(CPB);
        send(2, 9'h055, 7, 2, 1'b0, 2, 2'b11, 1'b1);
        tick(CPB);
        send(2, 9'h02A, 7, 2, 1'b0, 2, 2'b01, 1'b1);
        rx_v[2] = 1'b1;
        tick(CPB * 2);
        send(2, 9'h07F, 7, 2, 1'b0, 2, 2'b11, 1'b1);
        tick(CPB * 2);
        chk("acc_8e1", acc1, 2);
        chk("acc_7o2", acc2, 4);

        // Start glitch is ignored
        base = acc0;
        rx_v[0] = 1'b0;
        tick(4);
        rx_v[0] = 1'b1;
        tick(CPB * 3);
        chk("glitch_no_frame", acc0 - base, 0);
        send(0, 9'h081, 8, 0, 1'b0, 1, 2'b11, 1'b1);
        tick(CPB * 2);

        // Break: low stop, line held low
        base = acc0;
        send(0, 9'h000, 8, 0, 1'b0, 1, 2'b00, 1'b1);
        tick(CPB * 40);
        chk("break_one_frame", acc0 - base, 1);
        rx_v[0] = 1'b1;
        tick(CPB * 2);
        send(0, 9'h07E, 8, 0, 1'b0, 1, 2'b11, 1'b1);
        tick(CPB * 2);

        // Overrun while consumer stalls
        base = ovcnt;
        data_ready = 1'b0;
        send(0, 9'h011, 8, 0, 1'b0, 1, 2'b11, 1'b1);
        send(0, 9'h022, 8, 0, 1'b0, 1, 2'b11, 1'b0);
        t22 = last_start;
        tick(CPB);
        chk("ovr_data_held", dout0, 8'h11);
        chk("ovr_valid_held", dv0, 1);
        chk("ovr_pulse_cycles", ovcnt - base, 1);
        chk("ovr_timing", ov_cyc - t22, LAT_8N1);
        data_ready = 1'b1;
        tick(2);
        send(0, 9'h033, 8, 0, 1'b0, 1, 2'b11, 1'b1);
        tick(CPB);
        chk("post_ovr_data", dout0, 8'h33);
        chk("ovr_none_after", ovcnt - base, 1);

        // Reset mid-frame
        base = acc0;
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        drive_bit(0, 1'b0);
        drive_bit(0, 1'b1);
        reset   = 1'b1;
        rx_v[0] = 1'b1;
        tick(1);
        chk("midrst_data_out", dout0, 0);
        chk("midrst_valid", dv0, 0);
        chk("midrst_flags", {pe0, fe0, bk0, ov0}, 0);
        reset = 1'b0;
        tick(CPB * 12);
        chk("midrst_no_frame", acc0 - base, 0);
        send(0, 9'h0C3, 8, 0, 1'b0, 1, 2'b11, 1'b1);
        tick(CPB * 2);
        chk("acc_8n1_final", acc0 - base, 1);

        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
